// File: rtl/accumulator_drain_if.sv
// Output stream bundle of the accumulator drain: valid/ready words with a last marker.
interface accumulator_drain_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/accumulator_drain.sv
// Sweeps the accumulator back-buffer bank by bank, entry by entry, and streams the words out
// through a 2-entry skid FIFO that hides the one-cycle array read latency.
//
// state    | meaning
// S_IDLE   | waiting for start; address outputs held at 0
// S_ISSUE  | issuing reads while FIFO occupancy + in-flight < 2
// S_WAIT   | all reads issued; waiting for the last word to handshake
// S_FINISH | one-cycle done pulse, then back to idle
module accumulator_drain #(
    parameter int BUFFER_WIDTH           = 8,
    parameter int TILE_SIZE              = 256,
    parameter int SMALLEST_ELEMENT_WIDTH = 4,
    parameter int BANK_COUNT             = 256
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [$clog2(BANK_COUNT):0]         bank_limit,
    input  logic [$clog2(BUFFER_WIDTH):0]       entry_limit,
    output logic [$clog2(TILE_SIZE)-1:0]        back_buffer_bank_read,
    output logic [$clog2(BUFFER_WIDTH)-1:0]     back_buffer_bank_entry,
    input  logic [4*SMALLEST_ELEMENT_WIDTH-1:0] back_buffer_data_read,
    accumulator_drain_if.master                 out_if,
    output logic                                busy,
    output logic                                done
);
    localparam int BLW = $clog2(BANK_COUNT) + 1;
    localparam int ELW = $clog2(BUFFER_WIDTH) + 1;
    localparam int BW  = $clog2(TILE_SIZE);
    localparam int EW  = $clog2(BUFFER_WIDTH);
    localparam int DW  = 4 * SMALLEST_ELEMENT_WIDTH;
    localparam logic [BLW-1:0] BANK_ONE  = BLW'(1);
    localparam logic [ELW-1:0] ENTRY_ONE = ELW'(1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

    state_t          state_q, state_d;
    logic [BLW-1:0]  bank_lim_q, bank_lim_d;
    logic [ELW-1:0]  entry_lim_q, entry_lim_d;
    logic [BLW-1:0]  bank_q, bank_d;
    logic [ELW-1:0]  entry_q, entry_d;
    logic            inflight_q, inflight_d;
    logic            inflight_last_q, inflight_last_d;
    logic [DW-1:0]   fifo_data_q [2];
    logic [DW-1:0]   fifo_data_d [2];
    logic            fifo_last_q [2];
    logic            fifo_last_d [2];
    logic            head_q, head_d;
    logic [1:0]      count_q, count_d;

    logic [1:0] occupancy;
    logic       issue;
    logic       last_issue;
    logic       entry_wrap;
    logic       handshake;
    logic       push;
    logic       pop;
    logic       wr_idx;

    // The in-flight word bypasses the FIFO when it is empty, so data reaches the
    // stream in the same cycle the array presents it.
    always_comb begin
        occupancy  = count_q + {1'b0, inflight_q};
        issue      = (state_q == S_ISSUE) && (occupancy < 2'd2);
        entry_wrap = (entry_q == entry_lim_q - ENTRY_ONE);
        last_issue = entry_wrap && (bank_q == bank_lim_q - BANK_ONE);

        out_if.out_valid = (count_q != 2'd0) || inflight_q;
        if (count_q != 2'd0) begin
            out_if.out_data = fifo_data_q[head_q];
            out_if.out_last = fifo_last_q[head_q];
        end else if (inflight_q) begin
            out_if.out_data = back_buffer_data_read;
            out_if.out_last = inflight_last_q;
        end else begin
            out_if.out_data = '0;
            out_if.out_last = 1'b0;
        end

        handshake = out_if.out_valid && out_if.out_ready;
        pop       = handshake && (count_q != 2'd0);
        push      = inflight_q && !(handshake && (count_q == 2'd0));
        wr_idx    = head_q ^ count_q[0];

        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        if (push) begin
            fifo_data_d[wr_idx] = back_buffer_data_read;
            fifo_last_d[wr_idx] = inflight_last_q;
        end
        head_d  = head_q ^ pop;
        count_d = count_q + {1'b0, push} - {1'b0, pop};

        inflight_d      = issue;
        inflight_last_d = issue && last_issue;

        back_buffer_bank_read  = (state_q == S_ISSUE) ? bank_q[BW-1:0]  : '0;
        back_buffer_bank_entry = (state_q == S_ISSUE) ? entry_q[EW-1:0] : '0;
    end

    always_comb begin
        state_d     = state_q;
        bank_lim_d  = bank_lim_q;
        entry_lim_d = entry_lim_q;
        bank_d      = bank_q;
        entry_d     = entry_q;
        busy        = (state_q != S_IDLE);
        done        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    bank_lim_d  = bank_limit;
                    entry_lim_d = entry_limit;
                    bank_d      = '0;
                    entry_d     = '0;
                    if ((bank_limit == '0) || (entry_limit == '0)) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    if (last_issue) begin
                        state_d = S_WAIT;
                    end else if (entry_wrap) begin
                        entry_d = '0;
                        bank_d  = bank_q + BANK_ONE;
                    end else begin
                        entry_d = entry_q + ENTRY_ONE;
                    end
                end
            end
            S_WAIT: begin
                // The last-marked word is the final one issued, so once it
                // handshakes the FIFO and the read pipe are necessarily empty.
                if (handshake && out_if.out_last) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            bank_lim_q      <= '0;
            entry_lim_q     <= '0;
            bank_q          <= '0;
            entry_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_data_q[0]  <= '0;
            fifo_data_q[1]  <= '0;
            fifo_last_q[0]  <= 1'b0;
            fifo_last_q[1]  <= 1'b0;
            head_q          <= 1'b0;
            count_q         <= 2'd0;
        end else begin
            assert (!(push && !pop && (count_q == 2'd2)));
            state_q         <= state_d;
            bank_lim_q      <= bank_lim_d;
            entry_lim_q     <= entry_lim_d;
            bank_q          <= bank_d;
            entry_q         <= entry_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            fifo_data_q     <= fifo_data_d;
            fifo_last_q     <= fifo_last_d;
            head_q          <= head_d;
            count_q         <= count_d;
        end
    end
endmodule

// File: tb/tb_accumulator_drain.sv
// Bench for accumulator_drain: registered array model, stream scoreboard, table of drains
// plus hand-written start-while-busy and reset-mid-drain sequences.
module tb_accumulator_drain;
    logic        clk;
    logic        reset;
    logic        start;
    logic [8:0]  bank_limit;
    logic [3:0]  entry_limit;
    logic [7:0]  bank_read;
    logic [2:0]  bank_entry;
    logic [15:0] data_read;
    logic        busy;
    logic        done;

    accumulator_drain_if #(.DATA_WIDTH(16)) ifc ();

    accumulator_drain dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
        .bank_limit             (bank_limit),
        .entry_limit            (entry_limit),
        .back_buffer_bank_read  (bank_read),
        .back_buffer_bank_entry (bank_entry),
        .back_buffer_data_read  (data_read),
        .out_if                 (ifc),
        .busy                   (busy),
        .done                   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank array model: one-cycle registered read returning 16'hBBEE.
    always @(posedge clk) data_read <= {bank_read, 5'b0, bank_entry};

    typedef struct {
        logic [15:0] d;
        logic        l;
    } exp_t;

    typedef struct {
        int bl;
        int el;
        bit rnd;
        int exp_done;
        int mid_start;
    } vec_t;

    exp_t   exp_q[$];
    exp_t   got;
    int     checks = 0;
    int     errors = 0;
    int     hs_total = 0;
    bit     ready_rand = 0;
    bit     prev_stall = 0;
    logic [15:0] prev_data;
    logic        prev_last;
    vec_t   vecs[9];

    initial begin
        ifc.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ifc.out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!(ifc.out_valid && ifc.out_data == prev_data && ifc.out_last == prev_last)) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b data=%h last=%0b, required valid=1 data=%h last=%0b",
                             ifc.out_valid, ifc.out_data, ifc.out_last, prev_data, prev_last);
                end
            end
            if (ifc.out_valid && ifc.out_ready) begin
                hs_total++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got data=%h, required no word", ifc.out_data);
                end else begin
                    got = exp_q.pop_front();
                    if (ifc.out_data !== got.d) begin
                        errors++;
                        $display("FAIL word_data: got %h, required %h", ifc.out_data, got.d);
                    end
                    checks++;
                    if (ifc.out_last !== got.l) begin
                        errors++;
                        $display("FAIL word_last: got %0b for data %h, required %0b", ifc.out_last, got.d, got.l);
                    end
                end
            end
            prev_stall = ifc.out_valid && !ifc.out_ready;
            prev_data  = ifc.out_data;
            prev_last  = ifc.out_last;
        end
    end

    task automatic check(input string name, input int got_v, input int req_v);
        checks++;
        if (got_v != req_v) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got_v, req_v);
        end
    endtask

    task automatic push_expected(input int bl, input int el);
        exp_t e;
        for (int b = 0; b < bl; b++) begin
            for (int en = 0; en < el; en++) begin
                e.d = {8'(b), 8'(en)};
                e.l = (b == bl - 1) && (en == el - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic check_idle_outputs();
        check("idle_valid", int'(ifc.out_valid), 0);
        check("idle_last", int'(ifc.out_last), 0);
        check("idle_data", int'(ifc.out_data), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_done", int'(done), 0);
        check("idle_bank_addr", int'(bank_read), 0);
        check("idle_entry_addr", int'(bank_entry), 0);
    endtask

    task automatic run_drain(input int bl, input int el, input bit rnd, input int exp_done, input int mid_start);
        int done_at;
        ready_rand = rnd;
        @(negedge clk);
        bank_limit  = 9'(bl);
        entry_limit = 4'(el);
        start       = 1'b1;
        push_expected(bl, el);
        @(posedge clk);
        #1;
        start       = 1'b0;
        bank_limit  = 9'd3;
        entry_limit = 4'd2;
        done_at     = -1;
        for (int c = 1; c <= 6000; c++) begin
            if (c == mid_start) begin
                start       = 1'b1;
                bank_limit  = 9'd1;
                entry_limit = 4'd1;
            end
            @(negedge clk);
            if (!busy) begin
                check("busy_during_drain", int'(busy), 1);
            end
            if (done) begin
                done_at = c;
                break;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        if (done_at < 0) begin
            check("done_timeout", 0, 1);
        end else if (exp_done >= 0) begin
            check($sformatf("done_cycle_%0dx%0d", bl, el), done_at, exp_done);
        end else begin
            check("done_seen", 1, 1 - int'(done_at < 0));
        end
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("busy_after_done", int'(busy), 0);
        check("done_single_pulse", int'(done), 0);
        check("words_remaining", exp_q.size(), 0);
        exp_q.delete();
        ready_rand = 0;
    endtask

    initial begin
        int base;
        reset       = 1'b1;
        start       = 1'b0;
        bank_limit  = '0;
        entry_limit = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs();

        vecs[0] = '{2,   3, 1'b0, 8,    0};
        vecs[1] = '{2,   3, 1'b1, -1,   0};
        vecs[2] = '{256, 8, 1'b0, 2050, 0};
        vecs[3] = '{0,   5, 1'b0, 1,    0};
        vecs[4] = '{3,   0, 1'b0, 1,    0};
        vecs[5] = '{1,   1, 1'b0, 3,    0};
        vecs[6] = '{4,   4, 1'b0, 18,   4};
        vecs[7] = '{8,   8, 1'b1, -1,   0};
        vecs[8] = '{5,   7, 1'b0, 37,   0};
        for (int i = 0; i < 9; i++) begin
            run_drain(vecs[i].bl, vecs[i].el, vecs[i].rnd, vecs[i].exp_done, vecs[i].mid_start);
        end

        // Reset after the third handshake while the next read is in flight.
        base = hs_total;
        @(negedge clk);
        bank_limit  = 9'd2;
        entry_limit = 4'd3;
        start       = 1'b1;
        push_expected(2, 3);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 20 && (hs_total - base) < 3; c++) begin
            @(posedge clk);
            #1;
        end
        check("reset_wait_three_words", int'((hs_total - base) >= 3), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs();
        exp_q.delete();
        run_drain(2, 3, 1'b0, 8, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/accumulator_drain.md
# accumulator_drain

Read-side sequencer for the accumulator bank array. After each tile it sweeps the back-buffer read port bank by bank and entry by entry, and presents the accumulated words as a valid/ready stream to the output writer. It absorbs the bank array's one-cycle read latency and downstream backpressure with a 2-entry skid FIFO. `busy` tells the tile controller to hold off `transfer` until the drain completes.

## Interface
- `BUFFER_WIDTH`, 8: entries per bank.
- `TILE_SIZE`, 256: sets the width of the bank index.
- `SMALLEST_ELEMENT_WIDTH`, 4: the word width is 4× this value (16 bits).
- `BANK_COUNT`, 256: number of banks in the array.
- `clk` in 1: single clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request a drain. Sampled only in IDLE.
- `bank_limit` in $clog2(BANK_COUNT)+1: number of banks to drain (0..BANK_COUNT). Latched on start.
- `entry_limit` in $clog2(BUFFER_WIDTH)+1: number of entries per bank (0..BUFFER_WIDTH). Latched on start.
- `back_buffer_bank_read` out $clog2(TILE_SIZE): bank select to the array.
- `back_buffer_bank_entry` out $clog2(BUFFER_WIDTH): entry select to the array.
- `back_buffer_data_read` in 4*SMALLEST_ELEMENT_WIDTH: word addressed in the previous cycle.
- `out_data` out 4*SMALLEST_ELEMENT_WIDTH: stream data.
- `out_valid` out 1: stream valid.
- `out_ready` in 1: stream ready.
- `out_last` out 1: marks the final word of the drain.
- `busy` out 1: high from the start-accept cycle until `done`, inclusive.
- `done` out 1: one-cycle pulse on completion.

## Operation
- State IDLE:
  - `start` = 1 latches both limits and zeroes the bank and entry counters.
  - If either limit is 0, go to FINISH. Otherwise go to ISSUE.
- State ISSUE: each cycle, issue one read when (FIFO occupancy + reads in flight) < 2.
  - Drive `bank_read` and `entry` from the counters.
  - Mark the read in flight; it lands in the FIFO at the next edge with `back_buffer_data_read`.
  - Counter order: entry increments first. It wraps at `entry_limit`-1 → 0 and bank increments.
  - The last issue (bank = `bank_limit`-1, entry = `entry_limit`-1) moves the FSM to WAIT.
- State WAIT: no new issues. Stay until the FIFO is empty, no read is in flight, and the last word has handshaked. Then go to FINISH.
- State FINISH: assert `done` for one cycle, return to IDLE.
- Skid FIFO:
  - 2 entries, first in, first out.
  - A handshake occurs when `out_valid` and `out_ready` are both high.
  - A push and a pop in the same cycle is legal at any occupancy.
  - The credit rule guarantees the FIFO never overflows. Overflow is an assertion failure.
- `out_last` = 1 only on the word from the final (bank, entry) pair. It is held with that word while it is stalled.
- `out_data` is passed through unmodified. `bitwidth` packing is the consumer's concern.
- `start` asserted while busy is ignored.
- Limits above the parameter maxima are illegal inputs and are not checked.
- `reset` in any state:
  - returns to IDLE;
  - empties the FIFO and clears the in-flight flag;
  - the word in flight is discarded.
- Reset values: `back_buffer_bank_read` = 0, `back_buffer_bank_entry` = 0, `out_data` = 0, `out_valid` = 0, `out_last` = 0, `busy` = 0, `done` = 0.
- In IDLE, the address outputs hold 0.

## Timing
- Start is accepted at edge T.
- First address is driven during cycle T+1. Its data enters the FIFO at edge T+2. `out_valid` = 1 from T+2.
- With `out_ready` held high, the block sustains 1 word per cycle with no bubbles.
- For N = `bank_limit`×`entry_limit` words with no stalls:
  - last handshake in cycle T+N+1;
  - `done` in cycle T+N+2;
  - `busy` falls after that cycle.
- With a zero limit: `done` in cycle T+1, no stream output.
- When `out_ready` deasserts, issue stops within one cycle. At most 2 words are buffered, and no word is lost or duplicated.
- `out_valid` and `out_data` are stable while stalled and change only after a handshake.

## Test plan
- Basic drain: reset, then start with `bank_limit` = 2, `entry_limit` = 3. The array model returns {bank,entry} encoded as 16'hBBEE. `out_ready` is high.
  - Required: 6 words in order 0000, 0001, 0002, 0100, 0101, 0102 on consecutive cycles.
  - `out_last` only on 0102; `done` one cycle later.
- Backpressure: same drain, with `out_ready` toggled pseudo-randomly at about 50%.
  - Required: identical sequence, no drops or duplicates, FIFO occupancy ≤ 2, data stable while stalled.
- Full array: `bank_limit` = 256, `entry_limit` = 8, `out_ready` high.
  - Required: 2048 words, bank wraps 255→done, `done` at T+2050.
- Zero limit: `bank_limit` = 0.
  - Required: `done` at T+1, `out_valid` never asserted, `busy` high for exactly 1 cycle.
- Start while busy: pulse `start` mid-drain with different limits.
  - Required: ignored; the original sequence completes unchanged.
- Reset mid-drain: assert `reset` after the 3rd handshake while a read is in flight.
  - Required: all outputs return to 0 on the next cycle.
  - A subsequent start drains from bank 0, entry 0.
